scan_bist_ctrl: RTL

//  On-chip scan test controller for the 8-bit scan chain. Sits on both ends of the chain: drives

---
 rtl/scan_bist_pkg.sv | 30 +++
 rtl/scan_bist_ctrl_lfsr16.sv | 30 +++
 rtl/scan_bist_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scan_bist_pkg.sv
// Shared types and helpers for the scan BIST controller: FSM state encoding,
// LFSR/MISR width, feedback tap positions and the shared 16-bit LFSR step.
package scan_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int LFSR_W = 16;

    // Feedback taps shared by the pattern generator and the signature register
    localparam int TAP_0 = 15;
    localparam int TAP_1 = 13;
    localparam int TAP_2 = 12;
    localparam int TAP_3 = 10;

    // One step of the Fibonacci LFSR; din is folded into the feedback bit,
    // which turns the generator (din=0) into a serial MISR.
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] v,
                                                       input logic              din);
        logic fb_s;
        fb_s = v[TAP_0] ^ v[TAP_1] ^ v[TAP_2] ^ v[TAP_3];
        return {v[LFSR_W-2:0], fb_s ^ din};
    endfunction

endpackage

// File: rtl/scan_bist_ctrl_lfsr16.sv
// 16-bit LFSR / serial MISR cell used for both ends of the scan chain.
// load has priority over step; q holds when neither is asserted.
module scan_lfsr16
    import scan_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    input  logic              din,
    output logic [LFSR_W-1:0] q
);

    // Shift register: reset value, reload, or one feedback step per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr16_next(q, din);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/scan_bist_ctrl.sv
// Scan BIST controller: drives scan_en/scan_in from an LFSR, compacts scan_out
// into a MISR over NUM_PATTERNS shift/capture rounds plus an unload, and
// reports the final signature and a compare against GOLDEN_SIG.
// Optional build macro SCAN_BIST_ABORT_EN adds an abort input after start.
module scan_bist_ctrl
    import scan_bist_pkg::*;
#(
    parameter int                CHAIN_LEN    = 8,
    parameter int                NUM_PATTERNS = 16,
    parameter int                CNT_W        = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
    parameter logic [LFSR_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SCAN_BIST_ABORT_EN
    input  logic              abort,
`endif
    input  logic              scan_out,
    output logic              scan_en,
    output logic              scan_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LFSR_W-1:0] signature,
    output logic [CNT_W-1:0]  pattern_cnt
);

    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    state_t            state_r;
    logic [SC_W-1:0]   shift_cnt_r;
    logic [CNT_W-1:0]  pattern_cnt_r;
    logic              scan_en_r;
    logic              scan_in_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [LFSR_W-1:0] signature_r;

    logic              abort_s;
    logic              start_ok_s;
    logic              abort_hit_s;
    logic              last_shift_s;
    logic [CNT_W:0]    pc_inc_s;
    logic              more_s;
    logic              gen_step_s;
    logic              misr_step_s;
    logic [LFSR_W-1:0] gen_q_s;
    logic [LFSR_W-1:0] misr_q_s;
    logic [LFSR_W-1:0] misr_next_s;
    logic              gen_unused_s;

`ifdef SCAN_BIST_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign abort_hit_s  = abort_s && ((state_r == ST_SHIFT) || (state_r == ST_CAPTURE) ||
                                      (state_r == ST_UNLOAD));
    assign last_shift_s = (shift_cnt_r == SC_W'(CHAIN_LEN - 1));
    assign pc_inc_s     = {1'b0, pattern_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign more_s       = (pc_inc_s < (CNT_W + 1)'(NUM_PATTERNS));

    // The first pattern's shifts only flush unknown chain contents, so the MISR skips them
    assign gen_step_s   = (state_r == ST_SHIFT);
    assign misr_step_s  = ((state_r == ST_SHIFT) && (pattern_cnt_r != {CNT_W{1'b0}})) ||
                          (state_r == ST_UNLOAD);
    assign misr_next_s  = lfsr16_next(misr_q_s, scan_out);

    // Only the two top generator bits leave the LFSR; the rest feed its own feedback
    assign gen_unused_s = ^gen_q_s[LFSR_W-3:0];

    scan_lfsr16 #(.RST_VAL(LFSR_SEED)) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok_s),
        .seed  (LFSR_SEED),
        .step  (gen_step_s),
        .din   (1'b0),
        .q     (gen_q_s)
    );

    scan_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok_s),
        .seed  (16'h0000),
        .step  (misr_step_s),
        .din   (scan_out),
        .q     (misr_q_s)
    );

    // Controller FSM; scan_in is precomputed as the generator MSB of the coming SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            shift_cnt_r   <= {SC_W{1'b0}};
            pattern_cnt_r <= {CNT_W{1'b0}};
            scan_en_r     <= 1'b0;
            scan_in_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            signature_r   <= 16'h0000;
        end else if (abort_hit_s) begin
            state_r     <= ST_IDLE;
            shift_cnt_r <= {SC_W{1'b0}};
            scan_en_r   <= 1'b0;
            scan_in_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        state_r       <= ST_SHIFT;
                        shift_cnt_r   <= {SC_W{1'b0}};
                        pattern_cnt_r <= {CNT_W{1'b0}};
                        scan_en_r     <= 1'b1;
                        scan_in_r     <= LFSR_SEED[LFSR_W-1];
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                    end else begin
                        scan_en_r <= 1'b0;
                        scan_in_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (last_shift_s) begin
                        state_r     <= ST_CAPTURE;
                        shift_cnt_r <= {SC_W{1'b0}};
                        scan_en_r   <= 1'b0;
                        scan_in_r   <= 1'b0;
                    end else begin
                        shift_cnt_r <= shift_cnt_r + SC_W'(1);
                        scan_in_r   <= gen_q_s[LFSR_W-2];
                    end
                end
                ST_CAPTURE: begin
                    pattern_cnt_r <= pc_inc_s[CNT_W-1:0];
                    scan_en_r     <= 1'b1;
                    if (more_s) begin
                        state_r   <= ST_SHIFT;
                        scan_in_r <= gen_q_s[LFSR_W-1];
                    end else begin
                        state_r   <= ST_UNLOAD;
                        scan_in_r <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (last_shift_s) begin
                        state_r     <= ST_DONE;
                        shift_cnt_r <= {SC_W{1'b0}};
                        scan_en_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        signature_r <= misr_next_s;
                        pass_r      <= (misr_next_s == GOLDEN_SIG);
                    end else begin
                        shift_cnt_r <= shift_cnt_r + SC_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    scan_en_r <= 1'b0;
                    scan_in_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign scan_en     = scan_en_r;
    assign scan_in     = scan_in_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign signature   = signature_r;
    assign pattern_cnt = pattern_cnt_r;

endmodule
